mem_bus_arbiter: RTL and testbench

//  Shares one downstream memory port between the core's two requesters: instruction fetch (IFU)
//  and load/store (LSU). Sits between core_top's fetch/LSU master ports and the memory/SoC bus.
//  One transaction outstanding at a time. Grants, holds the request until accepted, then routes
//  the response back to the granted requester.

---
 rtl/mem_bus_arbiter.sv | 144 ++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - two-requester (IFU/LSU) arbiter onto a single memory port; ARB_RR_EN selects round-robin tie-break
module mem_bus_arbiter #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_ifu_valid,
    output logic                o_ifu_ready,
    input  logic [ADDR_W-1:0]   i_ifu_addr,
    output logic                o_ifu_rvalid,
    output logic [DATA_W-1:0]   o_ifu_rdata,
    input  logic                i_lsu_valid,
    output logic                o_lsu_ready,
    input  logic [ADDR_W-1:0]   i_lsu_addr,
    input  logic                i_lsu_wen,
    input  logic [DATA_W-1:0]   i_lsu_wdata,
    input  logic [DATA_W/8-1:0] i_lsu_wmask,
    output logic                o_lsu_rvalid,
    output logic [DATA_W-1:0]   o_lsu_rdata,
    output logic                o_mem_valid,
    input  logic                i_mem_ready,
    output logic [ADDR_W-1:0]   o_mem_addr,
    output logic                o_mem_wen,
    output logic [DATA_W-1:0]   o_mem_wdata,
    output logic [DATA_W/8-1:0] o_mem_wmask,
    input  logic                i_mem_rvalid,
    input  logic [DATA_W-1:0]   i_mem_rdata,
    output logic                o_owner
);
    localparam int MASK_W = DATA_W / 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                owner_q, owner_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                wen_q, wen_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [MASK_W-1:0]   wmask_q, wmask_d;
    logic                grant_lsu;

    // Tie-break: LSU wins when it requests alone, or on a tie per the selected policy.
    // In round-robin mode owner_q doubles as the last-winner flag; it resets to IFU so the first tie goes to LSU.
    always_comb begin
`ifdef ARB_RR_EN
        grant_lsu = i_lsu_valid && (!i_ifu_valid || !owner_q);
`else
        grant_lsu = i_lsu_valid;
`endif
    end

    // State register and latched request fields; reset also abandons any in-flight transaction.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            owner_q <= 1'b0;
            addr_q  <= '0;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            wmask_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            addr_q  <= addr_d;
            wen_q   <= wen_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
        end
    end

    // Next-state, grant/latch, downstream request and response routing.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        addr_d       = addr_q;
        wen_d        = wen_q;
        wdata_d      = wdata_q;
        wmask_d      = wmask_q;
        o_ifu_ready  = 1'b0;
        o_lsu_ready  = 1'b0;
        o_mem_valid  = 1'b0;
        o_ifu_rvalid = 1'b0;
        o_lsu_rvalid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_ifu_valid || i_lsu_valid) begin
                    state_d = ST_REQ;
                    owner_d = grant_lsu;
                    if (grant_lsu) begin
                        o_lsu_ready = 1'b1;
                        addr_d      = i_lsu_addr;
                        wen_d       = i_lsu_wen;
                        wdata_d     = i_lsu_wdata;
                        wmask_d     = i_lsu_wmask;
                    end else begin
                        o_ifu_ready = 1'b1;
                        addr_d      = i_ifu_addr;
                        wen_d       = 1'b0;
                        wdata_d     = '0;
                        wmask_d     = '0;
                    end
                end
            end
            ST_REQ: begin
                o_mem_valid = 1'b1;
                if (i_mem_ready) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (i_mem_rvalid) begin
                    o_ifu_rvalid = !owner_q;
                    o_lsu_rvalid = owner_q;
                    state_d      = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Keep every handshake output quiet while reset is held, even if requesters are asserting valid.
        if (!i_rst_n) begin
            o_ifu_ready  = 1'b0;
            o_lsu_ready  = 1'b0;
            o_mem_valid  = 1'b0;
            o_ifu_rvalid = 1'b0;
            o_lsu_rvalid = 1'b0;
        end
    end

    assign o_mem_addr  = addr_q;
    assign o_mem_wen   = wen_q;
    assign o_mem_wdata = wdata_q;
    assign o_mem_wmask = wmask_q;
    assign o_owner     = owner_q;
    assign o_ifu_rdata = i_mem_rdata;
    assign o_lsu_rdata = i_mem_rdata;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - self-checking bench for mem_bus_arbiter
module tb_mem_bus_arbiter;
    localparam int AW = 64;
    localparam int DW = 64;
    localparam int MW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ifu_valid = 1'b0, lsu_valid = 1'b0, lsu_wen = 1'b0;
    logic          mem_ready = 1'b0, mem_rvalid = 1'b0;
    logic [AW-1:0] ifu_addr = '0, lsu_addr = '0;
    logic [DW-1:0] lsu_wdata = '0, mem_rdata = '0;
    logic [MW-1:0] lsu_wmask = '0;
    logic          ifu_ready, lsu_ready, ifu_rvalid, lsu_rvalid, mem_valid, mem_wen, owner;
    logic [DW-1:0] ifu_rdata, lsu_rdata, mem_wdata;
    logic [AW-1:0] mem_addr;
    logic [MW-1:0] mem_wmask;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_ifu_valid(ifu_valid), .o_ifu_ready(ifu_ready), .i_ifu_addr(ifu_addr),
        .o_ifu_rvalid(ifu_rvalid), .o_ifu_rdata(ifu_rdata),
        .i_lsu_valid(lsu_valid), .o_lsu_ready(lsu_ready), .i_lsu_addr(lsu_addr),
        .i_lsu_wen(lsu_wen), .i_lsu_wdata(lsu_wdata), .i_lsu_wmask(lsu_wmask),
        .o_lsu_rvalid(lsu_rvalid), .o_lsu_rdata(lsu_rdata),
        .o_mem_valid(mem_valid), .i_mem_ready(mem_ready), .o_mem_addr(mem_addr),
        .o_mem_wen(mem_wen), .o_mem_wdata(mem_wdata), .o_mem_wmask(mem_wmask),
        .i_mem_rvalid(mem_rvalid), .i_mem_rdata(mem_rdata), .o_owner(owner)
    );

    int checks = 0;
    int failures = 0;

    // Reference arbitration state: which requester won the most recent grant (1 = LSU).
    bit model_last_lsu = 1'b0;

    // Observations gathered by drive_txn for the tests to judge.
    int            obs_ifu_ready, obs_lsu_ready, obs_hs, obs_unstable;
    int            obs_ifu_rv, obs_lsu_rv, obs_memv_resp, obs_cycles;
    logic          obs_owner, obs_wen;
    logic [AW-1:0] obs_addr;
    logic [DW-1:0] obs_wdata, obs_rdata;
    logic [MW-1:0] obs_wmask;

    // Spec rule: a lone requester wins; on a tie fixed mode favours LSU, round-robin favours whoever lost last time.
    function automatic bit exp_lsu_wins(input bit iv, input bit lv, input bit last_lsu);
        if (!iv) return lv;
        if (!lv) return 1'b0;
`ifdef ARB_RR_EN
        return !last_lsu;
`else
        return 1'b1;
`endif
    endfunction

    // Runs one full transaction from IDLE; ready after rdly stalled REQ cycles, response after sdly idle RESP cycles.
    task automatic drive_txn(input bit iv, input bit lv, input logic [AW-1:0] ia, input logic [AW-1:0] la,
                             input bit w, input logic [DW-1:0] wd, input logic [MW-1:0] wm,
                             input int rdly, input int sdly, input logic [DW-1:0] rd);
        ifu_valid = iv; lsu_valid = lv; ifu_addr = ia; lsu_addr = la;
        lsu_wen = w; lsu_wdata = wd; lsu_wmask = wm;
        mem_ready = 1'b0; mem_rvalid = 1'b0;
        obs_hs = 0; obs_unstable = 0; obs_ifu_rv = 0; obs_lsu_rv = 0; obs_memv_resp = 0;
        obs_rdata = 'x; obs_addr = 'x; obs_wen = 1'bx; obs_wdata = 'x; obs_wmask = 'x;
        @(negedge clk);
        obs_ifu_ready = int'(ifu_ready);
        obs_lsu_ready = int'(lsu_ready);
        obs_cycles = 1;
        @(posedge clk); #1;
        if (obs_ifu_ready != 0) ifu_valid = 1'b0;
        if (obs_lsu_ready != 0) lsu_valid = 1'b0;
        obs_owner = owner;
        for (int k = 0; k <= rdly; k++) begin
            mem_ready = (k == rdly);
            @(negedge clk);
            if (!mem_valid) obs_unstable++;
            else if (k == 0) begin
                obs_addr = mem_addr; obs_wen = mem_wen; obs_wdata = mem_wdata; obs_wmask = mem_wmask;
            end else if (mem_addr !== obs_addr || mem_wen !== obs_wen ||
                         mem_wdata !== obs_wdata || mem_wmask !== obs_wmask) obs_unstable++;
            if (mem_valid && mem_ready) obs_hs++;
            @(posedge clk); #1;
            obs_cycles++;
        end
        mem_ready = 1'b0;
        for (int k = 0; k <= sdly; k++) begin
            mem_rvalid = (k == sdly);
            mem_rdata = (k == sdly) ? rd : {$urandom, $urandom};
            @(negedge clk);
            obs_ifu_rv += int'(ifu_rvalid);
            obs_lsu_rv += int'(lsu_rvalid);
            if (ifu_rvalid) obs_rdata = ifu_rdata;
            if (lsu_rvalid) obs_rdata = lsu_rdata;
            if (mem_valid) obs_memv_resp++;
            @(posedge clk); #1;
            obs_cycles++;
        end
        mem_rvalid = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; ifu_valid = 1'b1; lsu_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if ({mem_valid, ifu_ready, lsu_ready, ifu_rvalid, lsu_rvalid, owner} !== 6'b0) begin
                failures++;
                $display("FAIL reset_outputs cycle=%0d got=%b want=000000", c,
                         {mem_valid, ifu_ready, lsu_ready, ifu_rvalid, lsu_rvalid, owner});
            end
        end
        @(posedge clk); #1;
        ifu_valid = 1'b0; lsu_valid = 1'b0; rst_n = 1'b1;
        model_last_lsu = 1'b0;
    endtask

    task automatic test_ifu_read;
        drive_txn(1'b1, 1'b0, 64'h8000_0000, '0, 1'b0, '0, '0, 0, 1, 64'h0000_0413);
        model_last_lsu = 1'b0;
        checks++;
        if (obs_ifu_ready != 1 || obs_lsu_ready != 0) begin
            failures++; $display("FAIL ifu_read_ready got=%0d/%0d want=1/0", obs_ifu_ready, obs_lsu_ready);
        end
        checks++;
        if (obs_hs != 1 || obs_addr !== 64'h8000_0000 || obs_wen !== 1'b0) begin
            failures++; $display("FAIL ifu_read_mem hs=%0d addr=%h wen=%b want 1/80000000/0", obs_hs, obs_addr, obs_wen);
        end
        checks++;
        if (obs_ifu_rv != 1 || obs_lsu_rv != 0 || obs_rdata !== 64'h0000_0413) begin
            failures++; $display("FAIL ifu_read_resp rv=%0d/%0d rdata=%h want 1/0/413", obs_ifu_rv, obs_lsu_rv, obs_rdata);
        end
        checks++;
        if (obs_cycles != 4) begin
            failures++; $display("FAIL ifu_read_cycles got=%0d want=4", obs_cycles);
        end
    endtask

    task automatic test_lsu_store;
        drive_txn(1'b0, 1'b1, '0, 64'h8000_1000, 1'b1, 64'hDEAD_BEEF, 8'h0F, 5, 2, 64'h0);
        model_last_lsu = 1'b1;
        checks++;
        if (obs_unstable != 0 || obs_hs != 1 || obs_memv_resp != 0) begin
            failures++; $display("FAIL store_stall unstable=%0d hs=%0d extra=%0d want 0/1/0", obs_unstable, obs_hs, obs_memv_resp);
        end
        checks++;
        if (obs_addr !== 64'h8000_1000 || obs_wen !== 1'b1 || obs_wdata !== 64'hDEAD_BEEF || obs_wmask !== 8'h0F) begin
            failures++; $display("FAIL store_fields addr=%h wen=%b wdata=%h wmask=%h", obs_addr, obs_wen, obs_wdata, obs_wmask);
        end
        checks++;
        if (obs_lsu_rv != 1 || obs_ifu_rv != 0 || obs_owner !== 1'b1) begin
            failures++; $display("FAIL store_resp lsu_rv=%0d ifu_rv=%0d owner=%b want 1/0/1", obs_lsu_rv, obs_ifu_rv, obs_owner);
        end
    endtask

    task automatic test_tie;
        logic [2:0] want;
`ifdef ARB_RR_EN
        want = 3'b101;
`else
        want = 3'b111;
`endif
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_last_lsu = 1'b0;
        for (int t = 0; t < 3; t++) begin
            drive_txn(1'b1, 1'b1, 64'h100 + AW'(t), 64'h200 + AW'(t), 1'b0, '0, '0, 0, 0, DW'(t));
            model_last_lsu = want[2-t];
            checks++;
            if (obs_owner !== want[2-t] || obs_lsu_ready != int'(want[2-t])) begin
                failures++; $display("FAIL tie_owner txn=%0d got=%b want=%b", t, obs_owner, want[2-t]);
            end
        end
        ifu_valid = 1'b0; lsu_valid = 1'b0;
    endtask

    task automatic test_reset_in_resp;
        lsu_valid = 1'b1; lsu_addr = 64'h40; lsu_wen = 1'b1;
        @(posedge clk); #1;
        lsu_valid = 1'b0; mem_ready = 1'b1;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_last_lsu = 1'b0;
        @(posedge clk); #1;
        mem_rvalid = 1'b1; mem_rdata = 64'h1234;
        @(negedge clk);
        checks++;
        if ({ifu_rvalid, lsu_rvalid, mem_valid, owner} !== 4'b0) begin
            failures++; $display("FAIL resp_after_reset got=%b want=0000", {ifu_rvalid, lsu_rvalid, mem_valid, owner});
        end
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        drive_txn(1'b1, 1'b0, 64'h8000_0040, '0, 1'b0, '0, '0, 1, 0, 64'h55);
        checks++;
        if (obs_owner !== 1'b0 || obs_ifu_rv != 1 || obs_rdata !== 64'h55 || obs_hs != 1) begin
            failures++; $display("FAIL post_reset_ifu owner=%b rv=%0d rdata=%h hs=%0d", obs_owner, obs_ifu_rv, obs_rdata, obs_hs);
        end
    endtask

    task automatic test_stray;
        mem_rvalid = 1'b1; mem_rdata = 64'hBAD;
        @(negedge clk);
        checks++;
        if ({ifu_rvalid, lsu_rvalid, mem_valid} !== 3'b0) begin
            failures++; $display("FAIL stray_resp got=%b want=000", {ifu_rvalid, lsu_rvalid, mem_valid});
        end
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        @(negedge clk);
        checks++;
        if ({mem_valid, ifu_ready, lsu_ready} !== 3'b0) begin
            failures++; $display("FAIL stray_idle got=%b want=000", {mem_valid, ifu_ready, lsu_ready});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random;
        bit            iv, lv, w, win;
        logic [AW-1:0] ia, la;
        logic [DW-1:0] wd, rd;
        logic [MW-1:0] wm;
        for (int n = 0; n < 24; n++) begin
            iv = 1'($urandom_range(0, 1));
            lv = 1'($urandom_range(0, 1));
            if (!iv && !lv) lv = 1'b1;
            ia = {$urandom, $urandom}; la = {$urandom, $urandom};
            w = 1'($urandom_range(0, 1)); wd = {$urandom, $urandom}; wm = MW'($urandom); rd = {$urandom, $urandom};
            win = exp_lsu_wins(iv, lv, model_last_lsu);
            drive_txn(iv, lv, ia, la, w, wd, wm, $urandom_range(0, 3), $urandom_range(0, 3), rd);
            model_last_lsu = win;
            checks++;
            if (obs_owner !== win || obs_lsu_ready != int'(win) || obs_ifu_ready != int'(!win)) begin
                failures++; $display("FAIL rand_grant n=%0d owner=%b ready=%0d/%0d want_lsu=%b", n, obs_owner, obs_ifu_ready, obs_lsu_ready, win);
            end
            checks++;
            if (obs_hs != 1 || obs_unstable != 0 || obs_memv_resp != 0 ||
                obs_addr !== (win ? la : ia) || obs_wen !== (win ? w : 1'b0) ||
                obs_wdata !== (win ? wd : '0) || obs_wmask !== (win ? wm : '0)) begin
                failures++; $display("FAIL rand_mem n=%0d hs=%0d unst=%0d addr=%h wen=%b wdata=%h wmask=%h", n, obs_hs, obs_unstable, obs_addr, obs_wen, obs_wdata, obs_wmask);
            end
            checks++;
            if (obs_lsu_rv != int'(win) || obs_ifu_rv != int'(!win) || obs_rdata !== rd) begin
                failures++; $display("FAIL rand_resp n=%0d rv=%0d/%0d rdata=%h want_rdata=%h", n, obs_ifu_rv, obs_lsu_rv, obs_rdata, rd);
            end
        end
        ifu_valid = 1'b0; lsu_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset;
        test_ifu_read;
        test_lsu_store;
        test_tie;
        test_reset_in_resp;
        test_stray;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
